priority_arbiter_rr: RTL
========================

// Module: priority_arbiter_rr
// PURPOSE
//  Parametrised N-way request arbiter. Successor to our 16-bit combinational priority encoder.
//  Arbitrates in one of two run-time modes:
//   - fixed priority: highest index wins
//   - round-robin: rotating priority
//  Registers the winner and presents it on a valid/ready grant handshake.
//  Sits between the tile's request inputs and downstream consumers that need a stable index.
// PARAMETERS
//  N      16             number of request lines (2..64)
//  IDX_W  $clog2(N)      width of the grant index (derived; do not override)
// PORTS
//  clk         in   1      system clock; all state on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  ena         in   1      arbitration enable; 0 = start no new grant
//  req         in   N      request vector, level-sensitive, bit i = requester i
//  mode        in   1      0 = fixed priority (MODE_FIXED), 1 = round-robin (MODE_RR)
//  gnt_ready   in   1      consumer accepts the current grant
//  gnt_valid   out  1      grant outputs hold a valid winner
//  gnt_idx     out  IDX_W  index of the granted requester
//  gnt_onehot  out  N      one-hot form of gnt_idx; all-zero when !gnt_valid
//  any_req     out  1      combinational |req
// BEHAVIOUR
//  Reset (async, rst_n=0): immediately, without clk, gnt_valid=0, gnt_idx=0, gnt_onehot=0,
//   last-grant pointer ptr=0, state=IDLE.
//  States:
//   IDLE  -> GRANT when ena && |req; winner registered at that edge.
//   GRANT -> hold until gnt_valid && gnt_ready.
//  Latency: req sampled at edge t; gnt_valid/gnt_idx valid from edge t (registered outputs,
//   visible the cycle after req is presented).
//  Winner selection (combinational, from req at the arbitration edge):
//   - MODE_FIXED: highest set index.
//   - MODE_RR: first set bit searching ptr-1, ptr-2, .., 0, N-1, .., ptr.
//     ptr=0 after reset, so the first RR grant equals the fixed-priority grant.
//  Grant hold: gnt_idx/gnt_onehot/gnt_valid are stable while gnt_valid && !gnt_ready.
//   A requester dropping req does not revoke its grant. req/mode changes have no effect until handshake.
//  Handshake edge (gnt_valid && gnt_ready):
//   - ptr <= gnt_idx.
//   - If ena && |req: re-arbitrate in the same cycle against the current req and stay in GRANT
//     (back-to-back, one grant per cycle). RR uses the just-granted index as ptr for this decision.
//   - Otherwise gnt_valid <= 0 and state -> IDLE.
//  ptr updates only on handshake, in both modes. Switching mode never resets ptr.
//  ena=0: no new arbitration; a grant already pending completes normally on gnt_ready.
//  req=0 in IDLE: stay in IDLE, outputs unchanged (gnt_valid=0).
//  gnt_ready while !gnt_valid: ignored.
//  Reset mid-grant: grant discarded, no handshake is generated.
//  mode is sampled only at an arbitration edge.
// STRUCTURE
//  Package arb_pkg:
//   - MODE_FIXED=1'b0, MODE_RR=1'b1
//   - state enum {S_IDLE, S_GRANT}
//   - function onehot_of(idx)
//  Sub-module pri_enc_n #(N): combinational highest-set-bit encoder; outputs idx and found.
//  Round-robin uses two pri_enc_n instances:
//   - masked pass on req & ((1<<ptr)-1)
//   - unmasked pass on req
//   - masked result wins if found, else unmasked result.
//  Top: FSM, ptr register, output registers.
// TESTING (N=16)
//  1. rst_n=0 mid-run with clk stopped -> gnt_valid=0, gnt_idx=0, gnt_onehot=0 at once;
//     after release, RR req=16'hFFFF -> first gnt_idx=15.
//  2. Fixed, req=16'h0891, gnt_ready=0 -> gnt_idx=11, gnt_onehot=16'h0800;
//     req then 16'h0001 for 5 cycles -> outputs unchanged; ready=1 -> next gnt_idx=0.
//  3. RR, req=16'hFFFF, gnt_ready=1 constantly -> gnt_idx 15,14,..,0,15 on consecutive cycles,
//     gnt_valid never drops.
//  4. RR, req=16'h8001, ready=1 -> 15,0,15,0.
//     Fixed with same stimulus -> 15,15,15.
//  5. req=0 -> gnt_valid stays 0.
//     ena=0 with req=16'h0010 -> no grant.
//     ena drops while grant pending, then ready=1 -> grant 4 completes, gnt_valid->0.
//  6. Mode switch fixed->RR while gnt_valid && !ready -> held grant unchanged;
//     next grant follows RR order from ptr.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared mode codes, FSM states and one-hot helper for the request arbiter.
package arb_pkg;

    localparam int MAX_N     = 64;
    localparam int MAX_IDX_W = 6;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    function automatic logic [MAX_N-1:0] onehot_of(input logic [MAX_IDX_W-1:0] idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/pri_enc_n.sv
// pri_enc_n: combinational highest-set-bit encoder over an N-bit vector.
module pri_enc_n #(
    parameter  int N     = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter_rr.sv
// priority_arbiter_rr: N-way fixed/round-robin arbiter with a registered
// winner held on a valid/ready grant handshake.
module priority_arbiter_rr
    import arb_pkg::*;
#(
    parameter  int N     = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             gnt_ready,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt_onehot,
    output logic             any_req
);

    state_t           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic             gnt_valid_q;
    logic [IDX_W-1:0] gnt_idx_q;
    logic [N-1:0]     gnt_onehot_q;

    logic [IDX_W-1:0] ptr_d;
    logic [N-1:0]     mask_d;
    logic [IDX_W-1:0] m_idx, f_idx, win_d;
    logic             m_found, f_found;
    logic [N-1:0]     win_oh_d;
    logic             arb_go;

    assign any_req = |req;
    assign arb_go  = ena && any_req;

    // On a handshake edge the just-granted index is the rotation point,
    // before ptr_q has caught up with it.
    assign ptr_d = (state_q == S_GRANT) ? gnt_idx_q : ptr_q;

    always_comb begin
        mask_d = '0;
        for (int i = 0; i < N; i++) mask_d[i] = IDX_W'(i) < ptr_d;
    end

    pri_enc_n #(.N(N)) u_masked (
        .req_i   (req & mask_d),
        .idx_o   (m_idx),
        .found_o (m_found)
    );

    pri_enc_n #(.N(N)) u_full (
        .req_i   (req),
        .idx_o   (f_idx),
        .found_o (f_found)
    );

    assign win_d    = (mode == MODE_RR && m_found) ? m_idx : f_idx;
    assign win_oh_d = N'(onehot_of(MAX_IDX_W'(win_d)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arb_go) begin
                        state_q      <= S_GRANT;
                        gnt_valid_q  <= 1'b1;
                        gnt_idx_q    <= win_d;
                        gnt_onehot_q <= win_oh_d;
                    end
                end
                S_GRANT: begin
                    if (gnt_valid_q && gnt_ready) begin
                        ptr_q <= gnt_idx_q;
                        if (arb_go) begin
                            gnt_idx_q    <= win_d;
                            gnt_onehot_q <= win_oh_d;
                        end else begin
                            state_q      <= S_IDLE;
                            gnt_valid_q  <= 1'b0;
                            gnt_onehot_q <= '0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;

    // f_found is implied by any_req; kept only for symmetry of the encoders.
    logic unused_ok;
    assign unused_ok = f_found;

endmodule
